// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
//
// Contents:
//   UART_FRAME_BITS     bits per 8N1 frame (start + 8 data + stop)
//   UART_DATA_BITS      data bits per frame
//   UART_CLK_DIV_16MHZ  clocks per bit for 115200 baud from a 16 MHz clock
//   tx_state_t          serializer FSM states
//   arb_state_t         arbiter FSM states
package uart_pkg;

    localparam int UART_FRAME_BITS    = 10;
    localparam int UART_DATA_BITS     = 8;
    localparam int UART_CLK_DIV_16MHZ = 139;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester-side valid/ready bundle for uart_tx_arbiter
//
// Signals (NREQ requesters):
//   req_valid[NREQ]     requester i has a byte to send
//   req_data[NREQ*8]    byte of requester i in bits [8i+7:8i]
//   req_ready[NREQ]     one-hot or zero; accept when valid && ready
//   req_lock[NREQ]      only with UART_TX_ARB_LOCK_EN: keep the grant on i
// Modports: master = requesters, slave = arbiter.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 2
);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_ready;

`ifdef UART_TX_ARB_LOCK_EN
    logic [NREQ-1:0]   req_lock;

    modport master (output req_valid, output req_data, output req_lock, input req_ready);
    modport slave  (input req_valid, input req_data, input req_lock, output req_ready);
`else
    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
`endif

endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 serializer with fixed clock divider
//
// Ports:
//   CLK, RST_N   clock, synchronous active-low reset
//   start        load data and begin a frame (honoured only when idle)
//   data[7:0]    byte to send, sampled on the start edge
//   line         registered serial output, idle high
//   done         one-cycle pulse during the last cycle of the stop bit
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_DIV = UART_CLK_DIV_16MHZ
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic [7:0] data,
    output logic       line,
    output logic       done
);

    localparam int             BW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [2:0]     BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_t     state, state_next;
    logic [BW-1:0] baud, baud_next;
    logic [2:0]    bit_cnt, bit_next;
    logic [7:0]    shift, shift_next;
    logic          line_q, line_next;
    logic          bit_end;

    assign bit_end = (baud == BAUD_LAST);
    assign line    = line_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= TX_IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            line_q  <= 1'b1;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_cnt <= bit_next;
            shift   <= shift_next;
            line_q  <= line_next;
        end
    end

    // The line is registered, so each branch loads the level of the bit that
    // starts on the coming edge; the shift register always presents the next
    // data bit at bit 0.
    always_comb begin
        state_next = state;
        baud_next  = baud;
        bit_next   = bit_cnt;
        shift_next = shift;
        line_next  = line_q;
        done       = 1'b0;

        case (state)
            TX_IDLE: begin
                if (start) begin
                    state_next = TX_START;
                    baud_next  = '0;
                    shift_next = data;
                    line_next  = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_next = TX_DATA;
                    baud_next  = '0;
                    bit_next   = '0;
                    line_next  = shift[0];
                    shift_next = {1'b0, shift[7:1]};
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    baud_next = '0;
                    bit_next  = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_next = TX_STOP;
                        line_next  = 1'b1;
                    end else begin
                        line_next  = shift[0];
                        shift_next = {1'b0, shift[7:1]};
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    state_next = TX_IDLE;
                    baud_next  = '0;
                    line_next  = 1'b1;
                    done       = 1'b1;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            default: begin
                state_next = TX_IDLE;
                line_next  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin per-byte arbiter driving one 8N1 UART line
//
// Ports:
//   CLK, RST_N           clock, synchronous active-low reset
//   req                  uart_tx_arbiter_if.slave request bundle (NREQ requesters)
//   uart_line_out        serial line, idle high
//   busy                 a frame is in flight
//   grant_id             index of the last accepted requester
// Build option: UART_TX_ARB_LOCK_EN adds req_lock to keep the grant on one requester.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int CLK_DIV = UART_CLK_DIV_16MHZ
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    uart_tx_arbiter_if.slave        req,
    output logic                    uart_line_out,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int            IW      = $clog2(NREQ);
    localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

    arb_state_t    state, state_next;
    logic [IW-1:0] rr_ptr, rr_next;
    logic [IW-1:0] grant_next;
    logic [IW-1:0] sel, scan_idx;
    logic          locked, locked_next;
    logic          found, accept, done;
    logic [7:0]    sel_data;
    logic [NREQ-1:0] lock_vec;

`ifdef UART_TX_ARB_LOCK_EN
    assign lock_vec = req.req_lock;
`else
    assign lock_vec = '0;
`endif

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
        return (p == LAST_ID) ? '0 : p + 1'b1;
    endfunction

    // First valid requester at or after rr_ptr, wrapping. While locked only
    // rr_ptr itself is eligible, so other requesters are starved on purpose.
    always_comb begin
        found    = 1'b0;
        sel      = rr_ptr;
        scan_idx = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req.req_valid[scan_idx] && (k == 0 || !locked)) begin
                found = 1'b1;
                sel   = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    assign accept   = (state == ARB_IDLE) && found && RST_N;
    assign sel_data = req.req_data[8*int'(sel) +: 8];
    assign busy     = (state == ARB_BUSY);

    always_comb begin
        req.req_ready = '0;
        if (accept) begin
            req.req_ready[sel] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            locked   <= 1'b0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_next;
            grant_id <= grant_next;
            locked   <= locked_next;
        end
    end

    always_comb begin
        state_next  = state;
        rr_next     = rr_ptr;
        grant_next  = grant_id;
        locked_next = locked;

        case (state)
            ARB_IDLE: begin
                if (accept) begin
                    state_next = ARB_BUSY;
                    grant_next = sel;
                    if (lock_vec[sel]) begin
                        rr_next     = sel;
                        locked_next = 1'b1;
                    end else begin
                        rr_next     = wrap_inc(sel);
                        locked_next = 1'b0;
                    end
                end
            end
            ARB_BUSY: begin
                if (done) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Serializer leaves TX_IDLE on the accept edge, so the start bit is on
    // the line from that same edge.
    uart_tx_serializer #(
        .CLK_DIV (CLK_DIV)
    ) u_ser (
        .CLK   (CLK),
        .RST_N (RST_N),
        .start (accept),
        .data  (sel_data),
        .line  (uart_line_out),
        .done  (done)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter (NREQ=2, CLK_DIV=4)
module tb_uart_tx_arbiter;

    localparam int NREQ    = 2;
    localparam int CLK_DIV = 4;
    localparam int FRAME   = 10 * CLK_DIV;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic       uart_line_out;
    logic       busy;
    logic [0:0] grant_id;
    logic [NREQ-1:0] lock_in;
    logic [NREQ-1:0] lock_eff;
    logic [9:0] pat55 = 10'b1010101010;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cnt [NREQ];

    uart_tx_arbiter_if #(.NREQ(NREQ)) rif ();

`ifdef UART_TX_ARB_LOCK_EN
    assign rif.req_lock = lock_in;
    assign lock_eff     = lock_in;
`else
    assign lock_eff     = '0;
`endif

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .req           (rif),
        .uart_line_out (uart_line_out),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Waits for a DUT accept; returns requester and the edge index of the accept.
    task automatic wait_accept(output int id, output int e);
        int got;
        got = -1;
        e   = -1;
        for (int n = 0; n < 200 && got < 0; n++) begin
            @(negedge CLK);
            for (int k = 0; k < NREQ; k++)
                if (RST_N && rif.req_valid[k] && rif.req_ready[k]) got = k;
        end
        if (got < 0) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: no accept within 200 cycles at cycle %0d", cyc);
        end
        @(posedge CLK);
        #1;
        e  = cyc;
        id = got;
    endtask

    // Accept counter on the DUT handshake.
    initial begin
        for (int k = 0; k < NREQ; k++) acc_cnt[k] = 0;
        forever begin
            @(negedge CLK);
            for (int k = 0; k < NREQ; k++)
                if (RST_N && rif.req_valid[k] && rif.req_ready[k]) acc_cnt[k]++;
        end
    end

    // Behavioural model: a frame is a start time plus a byte; the line level is
    // picked from the frame age, grants follow the round-robin rule directly.
    bit         m_ok     = 0;
    bit         m_active = 0;
    bit         m_lock   = 0;
    int         m_age    = 0;
    int         m_rr     = 0;
    int         m_gid    = 0;
    logic [7:0] m_byte   = 8'h00;

    function automatic logic m_line();
        int b;
        if (!m_active) return 1'b1;
        b = m_age / CLK_DIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        return 1'b1;
    endfunction

    function automatic int m_pick();
        if (m_active || !RST_N) return -1;
        if (m_lock) return rif.req_valid[m_rr] ? m_rr : -1;
        for (int k = 0; k < NREQ; k++)
            if (rif.req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        return -1;
    endfunction

    initial begin
        int pick;
        logic [NREQ-1:0] exp_ready;
        forever begin
            @(negedge CLK);
            pick      = m_pick();
            exp_ready = '0;
            if (pick >= 0) exp_ready[pick] = 1'b1;
            if (m_ok) begin
                check("line", uart_line_out, m_line());
                check("busy", busy, m_active);
                check("grant_id", grant_id, m_gid);
                check("req_ready", rif.req_ready, exp_ready);
            end
            if (!RST_N) begin
                m_ok = 1; m_active = 0; m_age = 0; m_rr = 0; m_gid = 0; m_lock = 0;
            end else if (m_ok) begin
                if (m_active) begin
                    m_age++;
                    if (m_age == FRAME) m_active = 0;
                end else if (pick >= 0) begin
                    m_active = 1;
                    m_age    = 0;
                    m_byte   = rif.req_data[pick*8 +: 8];
                    m_gid    = pick;
                    if (lock_eff[pick]) begin
                        m_rr = pick; m_lock = 1;
                    end else begin
                        m_rr = (pick + 1) % NREQ; m_lock = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int id, e, base1;
        int ids [4];
        int es  [4];
        logic [7:0] t3_bytes [3];
        t3_bytes[0] = 8'h3C; t3_bytes[1] = 8'hC3; t3_bytes[2] = 8'h81;

        rif.req_valid = '0;
        rif.req_data  = '0;
        lock_in       = '0;
        RST_N         = 1'b0;
        step(3);
        check("rst_line", uart_line_out, 1);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_ready", rif.req_ready, 0);
        RST_N = 1'b1;
        step(2);

        // Single byte 0x55 from req0.
        rif.req_data[7:0] = 8'h55;
        rif.req_valid[0]  = 1'b1;
        wait_accept(id, e);
        check("t1_id", id, 0);
        rif.req_valid[0] = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge CLK);
            check("t1_line", uart_line_out, pat55[i/CLK_DIV]);
            check("t1_busy", busy, 1);
            check("t1_grant", grant_id, 0);
        end
        @(negedge CLK);
        check("t1_busy_end", busy, 0);
        check("t1_line_end", uart_line_out, 1);
        step(2);

        // req1 pulsed one cycle while a req0 frame is in flight.
        rif.req_data[7:0] = 8'h12;
        rif.req_valid[0]  = 1'b1;
        wait_accept(id, e);
        check("t6_id", id, 0);
        rif.req_valid[0] = 1'b0;
        base1 = acc_cnt[1];
        step(10);
        rif.req_data[15:8] = 8'hEE;
        rif.req_valid[1]   = 1'b1;
        step(1);
        rif.req_valid[1] = 1'b0;
        step(FRAME);
        check("t6_no_accept", acc_cnt[1], base1);

        // Both valid from reset exit: alternate grants, 41-cycle spacing.
        RST_N         = 1'b0;
        rif.req_data  = 16'h0BA0;
        rif.req_valid = 2'b11;
        step(2);
        RST_N = 1'b1;
        for (int j = 0; j < 4; j++) wait_accept(ids[j], es[j]);
        rif.req_valid = '0;
        for (int j = 0; j < 4; j++) check("t2_order", ids[j], j % 2);
        for (int j = 1; j < 4; j++) check("t2_spacing", es[j] - es[j-1], 41);
        step(FRAME + 2);

        // Only req1 streams three bytes back-to-back.
        rif.req_data[15:8] = t3_bytes[0];
        rif.req_valid[1]   = 1'b1;
        for (int j = 0; j < 3; j++) begin
            wait_accept(ids[j], es[j]);
            if (j < 2) rif.req_data[15:8] = t3_bytes[j+1];
            else rif.req_valid[1] = 1'b0;
            @(negedge CLK);
            check("t3_grant", grant_id, 1);
            check("t3_id", ids[j], 1);
        end
        for (int j = 1; j < 3; j++) check("t3_spacing", es[j] - es[j-1], 41);
        step(FRAME + 2);

        // Reset pulse at cycle 15 of a 0xFF frame.
        rif.req_data[7:0] = 8'hFF;
        rif.req_valid[0]  = 1'b1;
        wait_accept(id, e);
        check("t4_id", id, 0);
        rif.req_valid[0] = 1'b0;
        step(14);
        RST_N = 1'b0;
        step(1);
        RST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("t4_line", uart_line_out, 1);
            check("t4_busy", busy, 0);
        end
        @(posedge CLK);
        #1;
        rif.req_data[15:8] = 8'h5A;
        rif.req_valid[1]   = 1'b1;
        @(negedge CLK);
        check("t4_ready", rif.req_ready, 2'b10);
        wait_accept(id, e);
        check("t4_id_after", id, 1);
        rif.req_valid[1] = 1'b0;
        step(FRAME + 2);

`ifdef UART_TX_ARB_LOCK_EN
        // req0 locks for two bytes while req1 waits.
        RST_N         = 1'b0;
        rif.req_data  = 16'h2201;
        rif.req_valid = 2'b11;
        lock_in       = 2'b01;
        step(2);
        RST_N = 1'b1;
        wait_accept(ids[0], es[0]);
        rif.req_valid[0] = 1'b0;
        step(FRAME + 5);
        rif.req_data[7:0] = 8'h02;
        rif.req_valid[0]  = 1'b1;
        wait_accept(ids[1], es[1]);
        rif.req_data[7:0] = 8'h03;
        lock_in           = 2'b00;
        wait_accept(ids[2], es[2]);
        rif.req_valid[0] = 1'b0;
        wait_accept(ids[3], es[3]);
        rif.req_valid[1] = 1'b0;
        check("t5_order0", ids[0], 0);
        check("t5_order1", ids[1], 0);
        check("t5_order2", ids[2], 0);
        check("t5_order3", ids[3], 1);
        step(FRAME + 2);
`endif

        step(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
